// File: rtl/cpu_pkg.sv
// Shared fetch-path types and defaults: address width, reset PC, fetch FSM states.
package cpu_pkg;

    localparam int          ADDR_W_DFLT   = 16;
    localparam logic [15:0] RESET_PC_DFLT = 16'h0000;
    localparam int          PC_STEP_DFLT  = 1;

    typedef logic [ADDR_W_DFLT-1:0] addr_t;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential step or branch target relative to instr_pc.
// Purely combinational; all sums wrap modulo 2^ADDR_W.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DFLT,
    parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_STEP_DFLT)
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              branch_sel,
    output logic [ADDR_W-1:0] seq_pc,
    output logic [ADDR_W-1:0] next_pc
);

    assign seq_pc  = pc + PC_STEP;
    assign next_pc = branch_sel ? (instr_pc + branch_offset) : seq_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over req/ack, feeds decode.
// Latency: 1 cycle from imem_ack to instr_valid; 1 instr/cycle with combinational ack.
// Backpressure: stall_in holds the output; one skid entry absorbs an in-flight word, then req drops.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DFLT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DFLT),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_STEP_DFLT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_data,
    input  logic              stall_in,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
);

    fetch_state_t      state_q, state_d;
    logic              boot_q, boot_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              out_vld_q, out_vld_d;
    logic [ADDR_W-1:0] out_dat_q, out_dat_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [ADDR_W-1:0] skid_dat_q, skid_dat_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic              br;
    logic              ack;
    logic              slot_free;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] next_pc;

    assign br        = branch_taken & out_vld_q;
    assign ack       = imem_ack & (state_q == S_REQ);
    assign slot_free = ~out_vld_q | ~stall_in;

    pc_next_calc #(
        .ADDR_W  (ADDR_W),
        .PC_STEP (PC_STEP)
    ) u_pc_next_calc (
        .pc            (pc_q),
        .instr_pc      (out_pc_q),
        .branch_offset (branch_offset),
        .branch_sel    (br),
        .seq_pc        (seq_pc),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        boot_d     = boot_q;
        kill_d     = kill_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_pc_d   = out_pc_q;
        skid_dat_d = skid_dat_q;
        skid_pc_d  = skid_pc_q;

        case (state_q)
            S_BOOT: begin
                boot_d  = 1'b1;
                state_d = boot_q ? S_REQ : S_BOOT;
            end
            S_REQ: begin
                if (kill_q) begin
                    // Redirected while the request was in flight: drop the word, then chase the target.
                    if (ack) begin
                        pc_d   = tgt_q;
                        kill_d = 1'b0;
                    end
                end else if (br) begin
                    out_vld_d = 1'b0;
                    if (ack) begin
                        pc_d = next_pc;
                    end else begin
                        kill_d = 1'b1;
                        tgt_d  = next_pc;
                    end
                end else if (ack) begin
                    pc_d = seq_pc;
                    if (slot_free) begin
                        out_dat_d = imem_data;
                        out_pc_d  = pc_q;
                        out_vld_d = 1'b1;
                    end else begin
                        skid_dat_d = imem_data;
                        skid_pc_d  = pc_q;
                        state_d    = S_FULL;
                    end
                end else if (!stall_in) begin
                    out_vld_d = 1'b0;
                end
            end
            S_FULL: begin
                if (br) begin
                    out_vld_d = 1'b0;
                    pc_d      = next_pc;
                    state_d   = S_REQ;
                end else if (!stall_in) begin
                    out_dat_d = skid_dat_q;
                    out_pc_d  = skid_pc_q;
                    state_d   = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            boot_q     <= 1'b0;
            kill_q     <= 1'b0;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_pc_q   <= '0;
            skid_dat_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            boot_q     <= boot_d;
            kill_q     <= kill_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_pc_q   <= out_pc_d;
            skid_dat_q <= skid_dat_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = out_vld_q;
    assign instr_out   = out_dat_q;
    assign instr_pc    = out_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Cycle-vector bench for pc_fetch_unit with an in-order scoreboard on the decode-side instruction stream.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    localparam addr_t MEM_KEY = 16'hBEEF;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  imem_req;
    addr_t imem_addr;
    logic  imem_ack;
    addr_t imem_data;
    logic  stall_in;
    logic  branch_taken;
    addr_t branch_offset;
    logic  instr_valid;
    addr_t instr_out;
    addr_t instr_pc;

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ MEM_KEY;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .stall_in      (stall_in),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    typedef struct {
        logic  stall;
        logic  ack;
        logic  br;
        addr_t off;
        logic  exp_req;
        addr_t exp_addr;
        logic  exp_vld;
        addr_t exp_pc;
        logic  is_new;
    } vec_t;

    vec_t  tbl[$];
    addr_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  last_vld = 1'b0;
    addr_t last_pc  = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs for one cycle, then the outputs expected just after that cycle's edge.
    task automatic add(input logic st, input logic ak, input logic b, input addr_t off,
                       input logic req, input addr_t addr, input logic vld, input addr_t pc);
        vec_t v;
        v.stall    = st;
        v.ack      = ak;
        v.br       = b;
        v.off      = off;
        v.exp_req  = req;
        v.exp_addr = addr;
        v.exp_vld  = vld;
        v.exp_pc   = pc;
        v.is_new   = vld && (!last_vld || last_pc != pc);
        last_vld   = vld;
        if (vld) last_pc = pc;
        tbl.push_back(v);
    endtask

    task automatic do_row(input vec_t v, input string tag);
        addr_t e;
        stall_in      = v.stall;
        imem_ack      = v.ack;
        branch_taken  = v.br;
        branch_offset = v.off;
        if (v.is_new) exp_q.push_back(v.exp_pc);
        #1;
        if (instr_valid && !stall_in) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_sb_extra: got pc %h expected no instruction", tag, instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_sb_pc", tag), 32'(instr_pc), 32'(e));
                chk($sformatf("%s_sb_dat", tag), 32'(instr_out), 32'(e ^ MEM_KEY));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s_req", tag), 32'(imem_req), 32'(v.exp_req));
        if (v.exp_req) chk($sformatf("%s_addr", tag), 32'(imem_addr), 32'(v.exp_addr));
        chk($sformatf("%s_vld", tag), 32'(instr_valid), 32'(v.exp_vld));
        if (v.exp_vld) begin
            chk($sformatf("%s_pc", tag), 32'(instr_pc), 32'(v.exp_pc));
            chk($sformatf("%s_out", tag), 32'(instr_out), 32'(v.exp_pc ^ MEM_KEY));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk($sformatf("%s_req", tag), 32'(imem_req), 32'd0);
        chk($sformatf("%s_vld", tag), 32'(instr_valid), 32'd0);
        chk($sformatf("%s_out", tag), 32'(instr_out), 32'd0);
        chk($sformatf("%s_pc", tag), 32'(instr_pc), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        stall_in      = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = '0;

        // Boot: two idle edges, then sequential fetch with ack tied high.
        add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
        for (int a = 1; a <= 4; a++) add(0, 1, 0, 16'h0000, 1, addr_t'(a), 1, addr_t'(a - 1));
        // Stall four cycles on 0x0003: 0x0004 lands in the skid, request drops, ack ignored.
        for (int k = 0; k < 4; k++) add(1, 1, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003);
        add(0, 1, 0, 16'h0000, 1, 16'h0005, 1, 16'h0004);
        add(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h0005);
        for (int a = 7; a <= 16'h11; a++) add(0, 1, 0, 16'h0000, 1, addr_t'(a), 1, addr_t'(a - 1));
        // Backward branch from 0x0010, same cycle as an ack.
        add(0, 1, 1, 16'hFFF8, 1, 16'h0008, 0, 16'h0000);
        for (int a = 9; a <= 16'h20; a++) add(0, 1, 0, 16'h0000, 1, addr_t'(a), 1, addr_t'(a - 1));
        // Branch while request to 0x0020 waits three cycles for ack.
        add(0, 0, 1, 16'h0021, 1, 16'h0020, 0, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0041, 1, 16'h0040);
        add(0, 1, 0, 16'h0000, 1, 16'h0042, 1, 16'h0041);
        // Wrap-around on sequential fetch and on branch target.
        add(0, 1, 1, 16'hFFBD, 1, 16'hFFFE, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'hFFFF, 1, 16'hFFFE);
        add(0, 1, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFF);
        add(0, 1, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000);
        add(0, 1, 1, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'hFFFF, 1, 16'hFFFE);
        add(0, 1, 1, 16'h0005, 1, 16'h0003, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h0003);
        // Fill the skid ahead of the asynchronous reset.
        add(1, 1, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) do_row(tbl[i], $sformatf("row%0d", i));
        chk("skid_pending_entries", 32'(exp_q.size()), 32'd1);

        // Asynchronous reset between edges with the skid full.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        last_vld = 1'b0;
        tbl.delete();
        @(negedge clk);
        rst_n = 1'b1;

        add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0001);
        add(0, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000);
        for (int i = 0; i < tbl.size(); i++) do_row(tbl[i], $sformatf("restart%0d", i));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
